// File: rtl/arb_burst_lock.sv
// Packet-lock stage around a round-robin arbiter: captures a one-hot grant and
// holds the granted channel on the single output port until its last beat is accepted.
module arb_burst_lock #(
    parameter int N   = 4,
    parameter int DW  = 8,
    parameter int IDW = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [N-1:0]    arb_req,
    input  logic [N-1:0]    arb_gnt,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic [IDW-1:0]  owner,
    output logic            busy,
    output logic [7:0]      beat_cnt,
    output logic            gnt_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_onehot;
    logic           gnt_hit;
    logic           accept;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx = IDW'(i);
            end
        end
    end

    assign gnt_onehot = (arb_gnt != '0) &&
                        ((arb_gnt & (arb_gnt - {{(N-1){1'b0}}, 1'b1})) == '0);
    assign gnt_hit    = |(arb_gnt & in_valid);

    // While reset is held the request vector is forced low so nothing leaks to the arbiter.
    always_comb begin
        arb_req   = '0;
        in_ready  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        if (state == LOCK) begin
            arb_req[owner]  = 1'b1;
            out_valid       = in_valid[owner];
            out_data        = in_data[owner*DW +: DW];
            out_last        = in_last[owner];
            in_ready[owner] = out_ready;
        end else if (rstn) begin
            arb_req = in_valid;
        end
    end

    assign accept = out_valid & out_ready;
    assign busy   = (state == LOCK);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            owner    <= '0;
            beat_cnt <= '0;
            gnt_err  <= 1'b0;
        end else if (state == IDLE) begin
            if (arb_gnt != '0) begin
                if (gnt_onehot && gnt_hit) begin
                    owner    <= gnt_idx;
                    beat_cnt <= '0;
                    state    <= LOCK;
                end else begin
                    gnt_err <= 1'b1;
                end
            end
        end else begin
            if (accept) begin
                if (beat_cnt != 8'hFF) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
                if (out_last) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule
